// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared state type and byte-lane helpers for the SPI-to-memory byte loader
package spi_mem_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINAL   = 2'd3
    } state_t;

    function automatic logic [1:0] lane_of(input logic [1:0] idx, input logic big_endian);
        return big_endian ? (2'(BYTES_PER_WORD - 1) - idx) : idx;
    endfunction

    // Lanes filled by the first 'count' bytes of a word.
    function automatic logic [3:0] lane_mask(input logic [2:0] count, input logic big_endian);
        logic [3:0] m;
        case (count)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return big_endian ? {m[0], m[1], m[2], m[3]} : m;
    endfunction

endpackage

// File: rtl/spi_mem_word_packer.sv
// rtl/spi_mem_word_packer.sv - packs accepted bytes into a 32-bit word and reports fill count and lane mask
module spi_mem_word_packer
    import spi_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  data_i,
    output logic [2:0]  count_o,
    output logic [31:0] word_o,
    output logic [3:0]  mask_o
);

    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [31:0] word_q;
    logic [1:0]  lane;

    assign lane  = lane_of(idx_q, BIG_ENDIAN);
    assign idx_d = idx_q + 2'd1;

    // Outputs already include the byte accepted this cycle so the word can be handed off immediately.
    always_comb begin
        word_o = word_q;
        if (accept_i) begin
            word_o[{lane, 3'b000} +: 8] = data_i;
        end
    end

    assign count_o = {1'b0, idx_q} + {2'b00, accept_i};
    assign mask_o  = lane_mask(count_o, BIG_ENDIAN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clear_i) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (accept_i) begin
            idx_q  <= idx_d;
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/spi_mem_byte_loader.sv
// rtl/spi_mem_byte_loader.sv - loads an SPI byte stream into sequential 32-bit memory words
module spi_mem_byte_loader
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              finish,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W:0]   words_written
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              fin_pend_q, fin_pend_d;
    logic              done_q, done_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic              pk_clear;
    logic              advance;
    logic [2:0]        pk_count;
    logic [31:0]       pk_word;
    logic [3:0]        pk_mask;

    assign accept   = in_valid && (state_q == COLLECT);
    assign pk_clear = ((state_q == IDLE) && start) || wr_d;

    spi_mem_word_packer #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (pk_clear),
        .accept_i(accept),
        .data_i  (in_data),
        .count_o (pk_count),
        .word_o  (pk_word),
        .mask_o  (pk_mask)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wrapped_d  = wrapped_q;
        words_d    = words_q;
        fin_pend_d = fin_pend_q;
        done_d     = 1'b0;
        wr_d       = 1'b0;
        maddr_d    = '0;
        be_d       = 4'b0000;
        wdata_d    = 32'd0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = start_addr;
                    wrapped_d  = 1'b0;
                    words_d    = '0;
                    fin_pend_d = 1'b0;
                    state_d    = COLLECT;
                end
            end
            COLLECT: begin
                // A byte arriving with finish is counted before finish is evaluated.
                if (pk_count == 3'(BYTES_PER_WORD)) begin
                    state_d    = WRITE;
                    fin_pend_d = finish;
                    wr_d       = 1'b1;
                end else if (finish) begin
                    if (pk_count != 3'd0) begin
                        state_d = FINAL;
                        wr_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                advance    = 1'b1;
                fin_pend_d = 1'b0;
                if (fin_pend_q || finish) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = COLLECT;
                end
            end
            FINAL: begin
                advance = 1'b1;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (wr_d) begin
            maddr_d = addr_q;
            be_d    = pk_mask;
            wdata_d = pk_word;
        end

        if (advance) begin
            addr_d = addr_q + 1'b1;
            if (addr_q == '1) begin
                wrapped_d = 1'b1;
            end
            if (words_q != '1) begin
                words_d = words_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wrapped_q  <= 1'b0;
            words_q    <= '0;
            fin_pend_q <= 1'b0;
            done_q     <= 1'b0;
            wr_q       <= 1'b0;
            maddr_q    <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wrapped_q  <= wrapped_d;
            words_q    <= words_d;
            fin_pend_q <= fin_pend_d;
            done_q     <= done_d;
            wr_q       <= wr_d;
            maddr_q    <= maddr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign in_ready       = (state_q == COLLECT);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign wrapped        = wrapped_q;
    assign words_written  = words_q;
    assign mem_write      = wr_q;
    assign mem_chipselect = wr_q;
    assign mem_address    = maddr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign mem_clken      = 1'b1;

endmodule
